// File: rtl/tx_resp_fifo.sv
// Response byte FIFO between the system controller and the UART TX path.
// Register-read bytes and 16-bit ALU results are queued, then launched one byte at a time.
module tx_resp_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RdDATA,
    input  logic                    RdDATA_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic                    Busy,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    FIFO_FULL,
    output logic                    Overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_full;
    logic                  r_overflow;
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_vld;

    logic [CNT_W-1:0]      w_free;
    logic                  w_alu_acc;
    logic                  w_rd_acc;
    logic                  w_drop;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_push_n;
    logic [CNT_W-1:0]      w_pop_n;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [PTR_W-1:0]      w_wptr_p1;

    // Space is judged on the start-of-cycle count; an ALU result needs two free
    // entries and wins over a simultaneous register read, which is then dropped.
    always_comb begin
        w_free      = DEPTH_C - r_count;
        w_alu_acc   = OUT_Valid && (w_free >= TWO_C);
        w_rd_acc    = RdDATA_VLD && !OUT_Valid && (w_free >= ONE_C);
        w_drop      = (OUT_Valid && !w_alu_acc) || (RdDATA_VLD && !w_rd_acc);
        w_pop       = (r_state == S_IDLE) && (r_count != '0) && !Busy;
        w_push_n    = w_alu_acc ? TWO_C : (w_rd_acc ? ONE_C : '0);
        w_pop_n     = w_pop ? ONE_C : '0;
        w_count_nxt = r_count + w_push_n - w_pop_n;
        w_wptr_p1   = r_wptr + PTR_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (w_alu_acc) begin
            r_mem[r_wptr]     <= ALU_OUT[DATA_WIDTH-1:0];
            r_mem[w_wptr_p1]  <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
        end else if (w_rd_acc) begin
            r_mem[r_wptr]     <= RdDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_alu_acc) begin
                r_wptr <= r_wptr + PTR_W'(2);
            end else if (w_rd_acc) begin
                r_wptr <= w_wptr_p1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // The request is a held level: the UART clock is slower, so only its
    // synchronized busy flag may close the handshake.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rptr];
                        r_tx_vld  <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (Busy) begin
                        r_tx_vld <= 1'b0;
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!Busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_tx_vld <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign TX_P_DATA = r_tx_data;
    assign TX_D_VLD  = r_tx_vld;
    assign FIFO_FULL = r_full;
    assign Overflow  = r_overflow;

endmodule

// File: tb/tb_tx_resp_fifo.sv
// Directed bench for tx_resp_fifo: a busy-flag model answers each launch and a
// byte scoreboard checks every launched byte against the bytes that were offered.
module tb_tx_resp_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rd_data;
    logic        rd_vld;
    logic [15:0] alu_out;
    logic        alu_vld;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        fifo_full;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q [$];

    logic auto_busy  = 1'b0;
    logic force_busy = 1'b0;
    logic model_busy = 1'b0;
    int   busy_dly   = 6;
    int   busy_hold  = 20;

    int launches   = 0;
    int launch_cyc = 0;
    int fall_cyc   = 0;
    int fall_cnt   = 0;
    int last_width = 0;
    int strobe_cyc = 0;

    assign busy = force_busy | model_busy;

    tx_resp_fifo #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4)
    ) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .RdDATA    (rd_data),
        .RdDATA_VLD(rd_vld),
        .ALU_OUT   (alu_out),
        .OUT_Valid (alu_vld),
        .Busy      (busy),
        .TX_P_DATA (tx_data),
        .TX_D_VLD  (tx_vld),
        .FIFO_FULL (fifo_full),
        .Overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every launch pops one expected byte, held cycles must keep it.
    initial begin : monitor
        logic       prev;
        logic [7:0] cur;
        int         len;
        prev = 1'b0;
        cur  = 8'h00;
        len  = 0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_vld) begin
                if (!prev) begin
                    launches++;
                    launch_cyc = cyc;
                    len = 1;
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_launch observed=%0h required=none", tx_data);
                    end
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check("tx_byte", tx_data, cur);
                    end else begin
                        cur = tx_data;
                    end
                end else begin
                    len++;
                    check("tx_hold", tx_data, cur);
                end
            end else if (prev) begin
                last_width = len;
            end
            prev = rst_n && tx_vld;
        end
    end

    // UART busy model: rises busy_dly cycles after a launch, holds busy_hold cycles.
    initial begin : busy_model
        forever begin
            @(negedge clk);
            if (auto_busy && rst_n && tx_vld) begin
                repeat (busy_dly - 1) @(negedge clk);
                model_busy = 1'b1;
                repeat (busy_hold) @(negedge clk);
                model_busy = 1'b0;
                fall_cyc = cyc;
                fall_cnt++;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic strobe_rd(input logic [7:0] d);
        rd_data    = d;
        rd_vld     = 1'b1;
        strobe_cyc = cyc;
        @(negedge clk);
        rd_vld     = 1'b0;
    endtask

    task automatic strobe_alu(input logic [15:0] d);
        alu_out    = d;
        alu_vld    = 1'b1;
        strobe_cyc = cyc;
        @(negedge clk);
        alu_vld    = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && (exp_q.size() != 0 || tx_vld || busy)) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_launches(input int target, input int budget);
        int n;
        n = 0;
        while (n < budget && launches < target) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("launch_reached", launches >= target, 1);
    endtask

    task automatic wait_fall(input int old, input int budget);
        int n;
        n = 0;
        while (n < budget && fall_cnt == old) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("busy_fall_seen", fall_cnt != old, 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin : main
        int base;
        rst_n   = 1'b0;
        rd_data = 8'h00;
        rd_vld  = 1'b0;
        alu_out = 16'h0000;
        alu_vld = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vld", tx_vld, 0);
        check("rst_data", tx_data, 0);
        check("rst_full", fifo_full, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single register-read byte with a slow busy response.
        auto_busy = 1'b1;
        busy_dly  = 6;
        busy_hold = 20;
        base = launches;
        exp_q.push_back(8'hA5);
        strobe_rd(8'hA5);
        wait_launches(base + 1, 20);
        check("t1_latency", launch_cyc - strobe_cyc, 2);
        drain(100);
        check("t1_width", last_width, 6);
        check("t1_ovf", overflow, 0);

        // ALU result: low byte first, relaunch two cycles after busy falls.
        base = launches;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        strobe_alu(16'h1234);
        wait_launches(base + 2, 200);
        check("t2_relaunch", launch_cyc - fall_cyc, 2);
        drain(100);
        check("t2_ovf", overflow, 0);

        // Fill to depth with busy held, third ALU result rejected.
        busy_dly   = 2;
        busy_hold  = 3;
        force_busy = 1'b1;
        @(negedge clk);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h22);
        alu_out = 16'h1111;
        alu_vld = 1'b1;
        @(negedge clk);
        check("t3_full_after1", fifo_full, 0);
        alu_out = 16'h2222;
        @(negedge clk);
        check("t3_full_after2", fifo_full, 1);
        check("t3_ovf_after2", overflow, 0);
        alu_out = 16'h3333;
        @(negedge clk);
        alu_vld = 1'b0;
        check("t3_full_after3", fifo_full, 1);
        check("t3_ovf_after3", overflow, 1);
        force_busy = 1'b0;
        drain(200);

        // Simultaneous strobes on an empty FIFO: ALU wins, read byte dropped.
        apply_reset();
        check("t4_ovf_clear", overflow, 0);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        rd_data = 8'h55;
        rd_vld  = 1'b1;
        alu_out = 16'hBEEF;
        alu_vld = 1'b1;
        @(negedge clk);
        rd_vld  = 1'b0;
        alu_vld = 1'b0;
        check("t4_ovf_set", overflow, 1);
        drain(100);

        // Three entries used: an ALU result needing two must be dropped whole.
        force_busy = 1'b1;
        @(negedge clk);
        exp_q.push_back(8'h3A);
        strobe_rd(8'h3A);
        exp_q.push_back(8'h5C);
        exp_q.push_back(8'h4B);
        strobe_alu(16'h4B5C);
        strobe_alu(16'h6D7E);
        check("t3b_full_at3", fifo_full, 0);
        force_busy = 1'b0;
        drain(200);

        // Streaming reads, each pushed on the edge that pops the previous byte.
        exp_q.push_back(8'h01);
        strobe_rd(8'h01);
        exp_q.push_back(8'h02);
        strobe_rd(8'h02);
        for (int k = 3; k <= 10; k++) begin
            wait_fall(fall_cnt, 60);
            @(negedge clk);
            exp_q.push_back(8'(k));
            strobe_rd(8'(k));
            check("t5_not_full", fifo_full, 0);
        end
        drain(200);

        // Asynchronous reset while a request is held with three bytes queued.
        auto_busy = 1'b0;
        exp_q.push_back(8'hC1);
        rd_vld  = 1'b1;
        rd_data = 8'hC1;
        @(negedge clk);
        rd_data = 8'hC2;
        @(negedge clk);
        rd_data = 8'hC3;
        @(negedge clk);
        rd_data = 8'hC4;
        @(negedge clk);
        rd_vld  = 1'b0;
        @(negedge clk);
        check("t6_in_req", tx_vld, 1);
        check("t6_ovf_before", overflow, 1);
        base = launches;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", tx_vld, 0);
        check("t6_rst_data", tx_data, 0);
        check("t6_rst_full", fifo_full, 0);
        check("t6_rst_ovf", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        auto_busy = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_quiet_vld", tx_vld, 0);
        check("t6_no_launch", launches, base);
        exp_q.push_back(8'h77);
        strobe_rd(8'h77);
        drain(100);
        check("t6_relaunched", launches, base + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
